// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the sequential divider: format constants,
// the unpacked-operand record and the operand decode helper.
`timescale 1ns/1ps
package fp32_pkg;

    localparam int unsigned EXP_BIAS  = 127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam int unsigned DIV_ITERS = 26;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;     // hidden bit included; zero for zero/denormal
        logic        is_zero;  // true zero or flushed denormal
        logic        is_inf;
        logic        is_nan;
    } fp32_unpacked_t;

    typedef enum logic [1:0] {
        StIdle,
        StUnpack,
        StDiv,
        StPack
    } div_state_e;

    // Result class decided at unpack time; SpNone selects the arithmetic path.
    typedef enum logic [1:0] {
        SpNone,
        SpNan,
        SpInf,
        SpZero
    } special_e;

    function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
        fp32_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.is_zero = (x[30:23] == 8'h00);
        u.is_inf  = (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
        u.is_nan  = (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
        u.mant    = u.is_zero ? 24'd0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Normalises a 26-bit restoring-division quotient, rounds to nearest-even
// and packs an FP32 result, saturating to Inf on overflow and flushing to
// signed zero on underflow.
`timescale 1ns/1ps
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic        sign_i,
    input  logic [9:0]  exp_i,     // biased exponent, two's complement
    input  logic [25:0] quo_i,     // quo_i[25] is the integer bit
    input  logic        sticky_i,  // nonzero remainder
    output logic [31:0] result_o
);

    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;
    logic [23:0]       mant_n;
    logic [24:0]       mant_r;
    logic [22:0]       frac_r;
    logic              guard;
    logic              sticky;
    logic              round_up;

    // Normalise into [1,2), round, renormalise on carry-out, then range-check.
    always_comb begin
        if (quo_i[25]) begin
            mant_n = quo_i[25:2];
            guard  = quo_i[1];
            sticky = quo_i[0] | sticky_i;
            exp_n  = $signed(exp_i);
        end else begin
            mant_n = quo_i[24:1];
            guard  = quo_i[0];
            sticky = sticky_i;
            exp_n  = $signed(exp_i) - 10'sd1;
        end

        round_up = guard & (sticky | mant_n[0]);
        mant_r   = {1'b0, mant_n} + {24'd0, round_up};

        if (mant_r[24]) begin
            frac_r = mant_r[23:1];
            exp_r  = exp_n + 10'sd1;
        end else begin
            frac_r = mant_r[22:0];
            exp_r  = exp_n;
        end

        if (exp_r >= 10'sd255) begin
            result_o = {sign_i, EXP_MAX, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            result_o = {sign_i, 31'd0};
        end else begin
            result_o = {sign_i, exp_r[7:0], frac_r};
        end
    end

endmodule

// File: rtl/new_div.sv
// Sequential FP32 divider, out = ia / ib. Fixed 28-cycle latency from the
// accepting edge: one unpack cycle, 26 restoring-division iterations and one
// round/pack cycle. Special operands take the same path so latency never varies.
`timescale 1ns/1ps
module new_div
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ia,
    input  logic [31:0] ib,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    div_state_e     state_q, state_d;
    logic [31:0]    a_raw_q, a_raw_d;
    logic [31:0]    b_raw_q, b_raw_d;
    logic           sign_q, sign_d;
    logic [9:0]     exp_q, exp_d;
    special_e       special_q, special_d;
    logic [25:0]    rem_q, rem_d;
    logic [25:0]    quo_q, quo_d;
    logic [23:0]    divisor_q, divisor_d;
    logic [4:0]     iter_q, iter_d;
    logic [31:0]    out_q, out_d;
    logic           done_q, done_d;

    fp32_unpacked_t    ua;
    fp32_unpacked_t    ub;
    logic signed [9:0] exp_calc;
    logic              rem_ge;
    logic [25:0]       rem_sub;
    logic [31:0]       rp_result;

    assign ua       = fp32_unpack(a_raw_q);
    assign ub       = fp32_unpack(b_raw_q);
    assign exp_calc = $signed({2'b00, ua.exp}) - $signed({2'b00, ub.exp}) + 10'sd127;

    // One restoring step: subtract when it fits, shift remainder for next bit.
    always_comb begin
        rem_ge  = (rem_q >= {2'b00, divisor_q});
        rem_sub = rem_ge ? (rem_q - {2'b00, divisor_q}) : rem_q;
    end

    fp32_round_pack u_round_pack (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .quo_i    (quo_q),
        .sticky_i (|rem_q),
        .result_o (rp_result)
    );

    // Next-state and datapath control for idle/unpack/divide/pack sequencing.
    always_comb begin
        state_d   = state_q;
        a_raw_d   = a_raw_q;
        b_raw_d   = b_raw_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        special_d = special_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        iter_d    = iter_q;
        out_d     = out_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_raw_d = ia;
                    b_raw_d = ib;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                sign_d    = ua.sign ^ ub.sign;
                exp_d     = exp_calc;
                rem_d     = {2'b00, ua.mant};
                divisor_d = ub.mant;
                quo_d     = '0;
                iter_d    = '0;
                if (ua.is_nan || ub.is_nan) begin
                    special_d = SpNan;
                end else if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
                    special_d = SpNan;
                end else if (ua.is_inf || ub.is_zero) begin
                    special_d = SpInf;
                end else if (ua.is_zero || ub.is_inf) begin
                    special_d = SpZero;
                end else begin
                    special_d = SpNone;
                end
                state_d = StDiv;
            end
            StDiv: begin
                rem_d  = {rem_sub[24:0], 1'b0};
                quo_d  = {quo_q[24:0], rem_ge};
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'(DIV_ITERS - 1)) begin
                    state_d = StPack;
                end
            end
            StPack: begin
                unique case (special_q)
                    SpNan:   out_d = QNAN;
                    SpInf:   out_d = {sign_q, EXP_MAX, 23'd0};
                    SpZero:  out_d = {sign_q, 31'd0};
                    default: out_d = rp_result;
                endcase
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            special_q <= SpNone;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            iter_q    <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_raw_q   <= a_raw_d;
            b_raw_q   <= b_raw_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            special_q <= special_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            iter_q    <= iter_d;
            out_q     <= out_d;
            done_q    <= done_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_new_div.sv
// Bench for new_div: directed vectors, random operands against an
// integer-arithmetic FP32 division model, and handshake/reset checks.
`timescale 1ns/1ps
module tb_new_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ia;
    logic [31:0] ib;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    new_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ia    (ia),
        .ib    (ib),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact quotient via wide integer division, then round-to-nearest-even.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int                ea, eb, e;
        logic [22:0]       fa, fb;
        logic              s;
        bit                az, ai, an, bz, bi, bn, guard, sticky;
        longint unsigned   ma, mb, n, q, r, mant;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        if (an || bn) return 32'h7FC0_0000;
        if ((az && bz) || (ai && bi)) return 32'h7FC0_0000;
        if (ai || bz) return {s, 8'hFF, 23'd0};
        if (az || bi) return {s, 31'd0};
        ma = (longint'(1) << 23) + longint'(fa);
        mb = (longint'(1) << 23) + longint'(fb);
        n  = ma << 30;
        q  = n / mb;
        r  = n % mb;
        e  = ea - eb + 127;
        if (q >= (longint'(1) << 30)) begin
            mant   = q >> 7;
            guard  = ((q >> 6) & 1) != 0;
            sticky = ((q & 63) != 0) || (r != 0);
        end else begin
            mant   = q >> 6;
            guard  = ((q >> 5) & 1) != 0;
            sticky = ((q & 31) != 0) || (r != 0);
            e      = e - 1;
        end
        if (guard && (sticky || ((mant & 1) != 0))) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] gen_operand();
        logic [31:0] v;
        int          cls;
        v   = $urandom;
        cls = int'($urandom_range(0, 11));
        case (cls)
            0: v[30:0]  = '0;
            1: begin v[30:23] = 8'h00; v[22:0] = 23'($urandom_range(1, 8388607)); end
            2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            3: begin v[30:23] = 8'hFF; v[22:0] = 23'($urandom_range(1, 8388607)); end
            4: v[30:23] = 8'($urandom_range(1, 4));
            5: v[30:23] = 8'($urandom_range(250, 254));
            6: begin v[30:23] = 8'($urandom_range(100, 150)); v[22:0] = 23'h7FFFFF; end
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1;
        ia    = a;
        ib    = b;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 28);
        chk(tag, out, ref_div(a, b));
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          ndone;
        int          first;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;

        rst   = 1'b1;
        start = 1'b0;
        ia    = '0;
        ib    = '0;
        #12;
        chk("rst_out", out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with literal expectations.
        do_op(32'h42D2_0000, 32'h4254_0000, "d105_53");
        chk("lit105_53", out, 32'h3FFD_95BC);
        do_op(32'h4356_0000, 32'h4254_0000, "d214_53");
        chk("lit214_53", out, 32'h4081_3522);
        do_op(32'h41C8_0000, 32'h4248_0000, "d25_50");
        chk("lit25_50", out, 32'h3F00_0000);
        do_op(32'h0000_0000, 32'h0000_000A, "dzero_den");
        chk("litzero_den", out, 32'h7FC0_0000);
        do_op(32'h3F80_0000, 32'h0000_0000, "ddivzero");
        chk("litdivzero", out, 32'h7F80_0000);
        do_op(32'h8000_0000, 32'h4000_0000, "dnegzero");
        chk("litnegzero", out, 32'h8000_0000);
        do_op(32'h7F00_0000, 32'h0080_0000, "dovf");
        chk("litovf", out, 32'h7F80_0000);
        do_op(32'h0080_0000, 32'h7F00_0000, "dunf");
        chk("litunf", out, 32'h0000_0000);

        // Random operands against the model.
        for (int i = 0; i < 250; i++) begin
            a = gen_operand();
            b = gen_operand();
            do_op(a, b, "rnd");
        end

        // A start while busy must be ignored: one done, first operands' result.
        @(negedge clk);
        start = 1'b1;
        ia    = 32'h42D2_0000;
        ib    = 32'h4254_0000;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = 0;
        res   = '0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    res   = out;
                end
            end
            if (c == 5) begin
                start = 1'b1;
                ia    = 32'h3F80_0000;
                ib    = 32'h0000_0000;
            end
            if (c == 6) start = 1'b0;
        end
        chk("busy_ndone", ndone, 1);
        chk("busy_lat", first, 28);
        chk("busy_res", res, 32'h3FFD_95BC);

        // Reset mid-operation aborts with no done, then a fresh op completes.
        @(negedge clk);
        start = 1'b1;
        ia    = 32'h4356_0000;
        ib    = 32'h4254_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out", out, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        do_op(32'h4356_0000, 32'h4254_0000, "post_rst");
        chk("litpost_rst", out, 32'h4081_3522);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
